voice_mixer: RTL and testbench
==============================

VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 The block SHALL have parameter NUM_GROUPS, default 64, setting the number of 4-word groups swept per sample (1..64).
REQ-002 The block SHALL have parameter SHIFT, default 8, setting the arithmetic right shift applied to the accumulator before output (0..24).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: sample-rate strobe that starts one mix.
REQ-006 The block SHALL have ports raddr0..raddr3, output, 8 bits each: read addresses to the 4-read-port voice RAM.
REQ-007 The block SHALL have ports dout0..dout3, input, 32 bits each: RAM read data, registered, valid one clock after the address edge.
REQ-008 The block SHALL have port sample, output, 16 bits, signed: the mixed output sample.
REQ-009 The block SHALL have port sample_valid, output, 1 bit: one-cycle pulse when sample updates.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when tick arrives while busy.

Function
REQ-012 Each RAM word SHALL be interpreted as: [15:0] signed sample; [23:16] unsigned gain; [31:24] ignored.
REQ-013 The block SHALL implement the FSM states IDLE, SWEEP, DRAIN and OUT.
REQ-014 IDLE transitions: tick=1 clears the 40-bit signed accumulator, sets group index g=0 and enters SWEEP; tick=0 stays in IDLE.
REQ-015 In SWEEP, the address outputs SHALL be raddrN = {g[5:0], N[1:0]}, and g SHALL increment each cycle.
REQ-016 SWEEP SHALL transition to DRAIN after the edge that issues g=NUM_GROUPS-1.
REQ-017 The accumulator SHALL add sum over N of (sample_N * gain_N), sign-extended to 40 bits, on every edge one cycle after an address edge; this covers NUM_GROUPS consecutive edges including the one leaving DRAIN.
REQ-018 DRAIN SHALL last one cycle, then enter OUT.
REQ-019 OUT SHALL register sample from (acc >>> SHIFT), assert sample_valid for exactly one cycle, and return to IDLE.
REQ-020 Latency: with tick sampled at edge E0, sample and sample_valid SHALL update at edge E0+NUM_GROUPS+2.
REQ-021 raddr0..3 SHALL be 0 in IDLE, DRAIN and OUT.
REQ-022 tick while busy=1, including during OUT, SHALL be ignored, and overrun SHALL pulse high for the following cycle.
REQ-023 sample SHALL hold its last value between sample_valid pulses.

Reset
REQ-024 reset=1 at any edge SHALL force IDLE and set accumulator=0, g=0, sample=0, sample_valid=0, busy=0, overrun=0 and raddr0..3=0.
REQ-025 A reset asserted mid-sweep SHALL abort the mix with no sample_valid pulse.
REQ-026 A tick coincident with reset SHALL be ignored.

Configuration
REQ-027 The saturation feature SHALL be controlled by the macro VOICE_MIXER_SATURATE_EN.
REQ-028 With VOICE_MIXER_SATURATE_EN defined, (acc >>> SHIFT) SHALL be clamped to the range [-32768, 32767] before being registered.
REQ-029 Without VOICE_MIXER_SATURATE_EN defined, sample SHALL be bits [15:0] of (acc >>> SHIFT), i.e. two's-complement wrap.

Verification
REQ-030 Zero mix: all 256 words = 0, SHIFT=8, tick -> sample=0, sample_valid pulse at E0+66.
REQ-031 Single voice: word 0 = 0x0002_0064, others 0, SHIFT=0 -> sample=200; RAM read-address trace matches REQ-015.
REQ-032 Saturation: all words = 0x00FF_7FFF, SHIFT=8 -> sample=32767 with VOICE_MIXER_SATURATE_EN defined; sample=32513 (0x7F01) without it.
REQ-033 Negative: word 5 = 0x00FF_8000, others 0, SHIFT=8 -> sample=-32640 in both configurations.
REQ-034 Overrun: tick at E0 and again at E10 -> overrun pulse after E10, exactly one sample_valid, at E0+66.
REQ-035 Reset mid-operation: tick at E0, reset at E20 -> outputs all 0, no sample_valid; a tick at E25 produces a valid sample at E25+66.

Source files
------------

// File: rtl/voice_mixer.sv
// Four-port voice RAM mixer: sweeps NUM_GROUPS groups of 4 words per tick, sums sample*gain and emits one sample.
// Optional output clamping is enabled by defining VOICE_MIXER_SATURATE_EN; otherwise the output wraps.
module voice_mixer #(
   parameter int NUM_GROUPS = 64,
   parameter int SHIFT      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   output logic [7:0]         raddr0,
   output logic [7:0]         raddr1,
   output logic [7:0]         raddr2,
   output logic [7:0]         raddr3,
   input  logic [31:0]        dout0,
   input  logic [31:0]        dout1,
   input  logic [31:0]        dout2,
   input  logic [31:0]        dout3,
   output logic signed [15:0] sample,
   output logic               sample_valid,
   output logic               busy,
   output logic               overrun
);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, OUT} state_t;

   localparam logic [5:0] LAST_G = 6'(NUM_GROUPS - 1);

   state_t                    state;
   state_t                    state_next;
   logic [5:0]                g;
   logic                      rd_valid;
   logic signed [39:0]        acc;
   logic signed [39:0]        mix_sum;
   logic signed [39:0]        shifted;
   logic signed [15:0]        sample_next;
   logic                      unused_hi_bits;

   // One voice contribution: signed sample times unsigned gain, sign-extended to accumulator width
   function automatic logic signed [39:0] voice_term(input logic [31:0] w);
      logic signed [24:0] s;
      logic signed [24:0] gn;
      logic signed [24:0] p;
      s  = {{9{w[15]}}, w[15:0]};
      gn = {17'd0, w[23:16]};
      p  = s * gn;
      return {{15{p[24]}}, p};
   endfunction

   assign unused_hi_bits = ^{dout0[31:24], dout1[31:24], dout2[31:24], dout3[31:24]};

   assign mix_sum = voice_term(dout0) + voice_term(dout1) + voice_term(dout2) + voice_term(dout3);
   assign shifted = acc >>> SHIFT;
   assign busy    = (state != IDLE);

   assign raddr0 = (state == SWEEP) ? {g, 2'd0} : 8'd0;
   assign raddr1 = (state == SWEEP) ? {g, 2'd1} : 8'd0;
   assign raddr2 = (state == SWEEP) ? {g, 2'd2} : 8'd0;
   assign raddr3 = (state == SWEEP) ? {g, 2'd3} : 8'd0;

`ifdef VOICE_MIXER_SATURATE_EN
   always_comb begin
      sample_next = shifted[15:0];
      if (shifted > 40'sd32767) begin
         sample_next = 16'sh7FFF;
      end else if (shifted < -40'sd32768) begin
         sample_next = 16'sh8000;
      end
   end
`else
   always_comb begin
      sample_next = shifted[15:0];
   end
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (tick) state_next = SWEEP;
         SWEEP:   if (g == LAST_G) state_next = DRAIN;
         DRAIN:   state_next = OUT;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Read data arrives one edge after its address, so accumulation trails the sweep by one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         acc          <= '0;
         g            <= '0;
         rd_valid     <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_next;
         sample_valid <= 1'b0;
         overrun      <= tick && busy;
         rd_valid     <= (state == SWEEP);
         if (rd_valid) begin
            acc <= acc + mix_sum;
         end
         case (state)
            IDLE: begin
               if (tick) begin
                  acc <= '0;
                  g   <= '0;
               end
            end
            SWEEP: begin
               g <= (g == LAST_G) ? 6'd0 : g + 6'd1;
            end
            OUT: begin
               sample       <= sample_next;
               sample_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: a behavioural RAM feeds two instances (SHIFT=8 and SHIFT=0);
// expected samples are queued at tick time and compared when sample_valid fires.
module tb_voice_mixer;

   localparam int NG = 64;

   typedef struct {
      logic signed [15:0] value;
      int                 due;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               tick = 1'b0;
   logic               tick_s = 1'b0;
   logic [7:0]         ra [4];
   logic [7:0]         ra_s [4];
   logic [31:0]        rd [4];
   logic [31:0]        rd_s [4];
   logic signed [15:0] smp;
   logic signed [15:0] smp_s;
   logic               sv, sv_s, busy, busy_s, ovr, ovr_s;
   logic [31:0]        mem [256];
   int                 cyc = 0;
   int                 tests = 0;
   int                 fails = 0;
   exp_t               q[$];
   exp_t               q_s[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered 4-port RAM shared by both instances
   always @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         rd[n]   <= mem[ra[n]];
         rd_s[n] <= mem[ra_s[n]];
      end
   end

   voice_mixer #(.NUM_GROUPS(NG), .SHIFT(8)) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .raddr0(ra[0]), .raddr1(ra[1]), .raddr2(ra[2]), .raddr3(ra[3]),
      .dout0(rd[0]), .dout1(rd[1]), .dout2(rd[2]), .dout3(rd[3]),
      .sample(smp), .sample_valid(sv), .busy(busy), .overrun(ovr)
   );

   voice_mixer #(.NUM_GROUPS(NG), .SHIFT(0)) dut_s0 (
      .clk(clk), .reset(reset), .tick(tick_s),
      .raddr0(ra_s[0]), .raddr1(ra_s[1]), .raddr2(ra_s[2]), .raddr3(ra_s[3]),
      .dout0(rd_s[0]), .dout1(rd_s[1]), .dout2(rd_s[2]), .dout3(rd_s[3]),
      .sample(smp_s), .sample_valid(sv_s), .busy(busy_s), .overrun(ovr_s)
   );

   // Arithmetic reference: full sum over the RAM, shift, then clamp or wrap
   function automatic logic signed [15:0] model(input int shift);
      logic signed [39:0] a;
      logic signed [39:0] s;
      logic signed [39:0] gn;
      a = '0;
      for (int i = 0; i < 4 * NG; i++) begin
         s  = {{24{mem[i][15]}}, mem[i][15:0]};
         gn = {32'd0, mem[i][23:16]};
         a  = a + s * gn;
      end
      a = a >>> shift;
`ifdef VOICE_MIXER_SATURATE_EN
      if (a > 40'sd32767) return 16'sh7FFF;
      if (a < -40'sd32768) return 16'sh8000;
`endif
      return a[15:0];
   endfunction

   task automatic fill(input logic [31:0] w);
      for (int i = 0; i < 256; i++) mem[i] = w;
   endtask

   task automatic do_tick();
      @(negedge clk);
      tick = 1'b1;
      q.push_back('{model(8), cyc + 1 + NG + 2});
      @(negedge clk);
      tick = 1'b0;
   endtask

   // Watches one instance for a bounded number of cycles, popping the scoreboard on each sample_valid
   task automatic collect(input bit s0, input int cycles);
      exp_t               e;
      logic               v;
      logic signed [15:0] val;
      int                 n;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         v   = s0 ? sv_s : sv;
         val = s0 ? smp_s : smp;
         if (v === 1'b1) begin
            n = s0 ? q_s.size() : q.size();
            tests++;
            if (n == 0) begin
               fails++;
               $display("[TB] FAIL unexpected_valid: got sample_valid=1 expected 0 at cycle %0d", cyc);
            end else begin
               if (s0) e = q_s.pop_front();
               else    e = q.pop_front();
               if (val !== e.value) begin
                  fails++;
                  $display("[TB] FAIL sample_value: got %0d expected %0d", val, e.value);
               end
               tests++;
               if (cyc !== e.due) begin
                  fails++;
                  $display("[TB] FAIL sample_latency: got cycle %0d expected %0d", cyc, e.due);
               end
            end
         end
      end
      n = s0 ? q_s.size() : q.size();
      tests++;
      if (n != 0) begin
         fails++;
         $display("[TB] FAIL sample_timeout: got %0d samples pending expected 0", n);
         q.delete();
         q_s.delete();
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      tick   = 1'b1;
      tick_s = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({smp, sv, busy, ovr} !== 19'd0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got %h expected 0", {smp, sv, busy, ovr});
      end
      tests++;
      if ({ra[0], ra[1], ra[2], ra[3]} !== 32'd0) begin
         fails++;
         $display("[TB] FAIL reset_raddr: got %h expected 0", {ra[0], ra[1], ra[2], ra[3]});
      end
      reset  = 1'b0;
      tick   = 1'b0;
      tick_s = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, busy_s, sv, sv_s} !== 4'd0) begin
         fails++;
         $display("[TB] FAIL reset_tick_ignored: got %b expected 0000", {busy, busy_s, sv, sv_s});
      end
   endtask

   task automatic test_zero_mix();
      fill(32'h0000_0000);
      do_tick();
      collect(1'b0, 80);
   endtask

   task automatic test_single_voice();
      int         e0;
      logic [5:0] kk;
      logic [31:0] want;
      fill(32'h0000_0000);
      mem[0] = 32'h0002_0064;
      @(negedge clk);
      tick_s = 1'b1;
      e0 = cyc + 1;
      q_s.push_back('{model(0), e0 + NG + 2});
      for (int k = 0; k < NG + 2; k++) begin
         @(negedge clk);
         tick_s = 1'b0;
         kk   = 6'(k);
         want = (k < NG) ? {kk, 2'd0, kk, 2'd1, kk, 2'd2, kk, 2'd3} : 32'd0;
         tests++;
         if ({ra_s[0], ra_s[1], ra_s[2], ra_s[3]} !== want) begin
            fails++;
            $display("[TB] FAIL addr_trace: got %h expected %h at step %0d",
                     {ra_s[0], ra_s[1], ra_s[2], ra_s[3]}, want, k);
         end
      end
      collect(1'b1, 20);
   endtask

   task automatic test_saturation();
      fill(32'h00FF_7FFF);
      do_tick();
      collect(1'b0, 80);
   endtask

   task automatic test_negative();
      fill(32'h0000_0000);
      mem[5] = 32'h00FF_8000;
      do_tick();
      collect(1'b0, 80);
      repeat (10) @(negedge clk);
      tests++;
      if (smp !== 16'sh8080 || sv !== 1'b0) begin
         fails++;
         $display("[TB] FAIL sample_hold: got %0d/%b expected -32640/0", smp, sv);
      end
   endtask

   task automatic test_overrun();
      int e0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      @(negedge clk);
      tick = 1'b1;
      e0 = cyc + 1;
      q.push_back('{model(8), e0 + NG + 2});
      @(negedge clk);
      tick = 1'b0;
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      tests++;
      if (ovr !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL overrun_pulse: got ovr=%b busy=%b expected 1/1", ovr, busy);
      end
      @(negedge clk);
      tests++;
      if (ovr !== 1'b0) begin
         fails++;
         $display("[TB] FAIL overrun_width: got %b expected 0", ovr);
      end
      collect(1'b0, 80);
   endtask

   task automatic test_reset_mid();
      int e0;
      @(negedge clk);
      tick = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      tick = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++;
      if ({smp, sv, busy, ovr} !== 19'd0 || {ra[0], ra[1], ra[2], ra[3]} !== 32'd0) begin
         fails++;
         $display("[TB] FAIL mid_reset: got %h/%h expected 0/0",
                  {smp, sv, busy, ovr}, {ra[0], ra[1], ra[2], ra[3]});
      end
      repeat (4) @(negedge clk);
      tick = 1'b1;
      q.push_back('{model(8), e0 + 25 + NG + 2});
      @(negedge clk);
      tick = 1'b0;
      collect(1'b0, 100);
   endtask

   initial begin
      fill(32'h0000_0000);
      test_reset();
      test_zero_mix();
      test_single_voice();
      test_saturation();
      test_negative();
      test_overrun();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
